note_hit_scorer: RTL

NOTE_HIT_SCORER -- requirements
Module: note_hit_scorer

---
 rtl/note_hit_scorer_if.sv | 29 ++
 rtl/note_hit_scorer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/note_hit_scorer_if.sv
// Bundle of game-control inputs and judging outputs for note_hit_scorer.
//
// Handshake semantics: there is no valid/ready flow control on this bus.
// Inputs are sampled on every rising edge of clk. tick and spawn are
// single-cycle strobes. btn is a debounced level, and its rising edge is a
// press. hit and miss are single-cycle registered pulses. score, streak and
// overflow are registered levels.
interface note_hit_scorer_if;
  logic       play;
  logic       tick;
  logic [2:0] spawn;
  logic [2:0] btn;
  logic [2:0] hit;
  logic [2:0] miss;
  logic [7:0] score;
  logic [5:0] streak;
  logic       overflow;
  logic       dbg_state;  // 1 = RUN, 0 = IDLE

  modport master (
    output play, tick, spawn, btn,
    input  hit, miss, score, streak, overflow, dbg_state
  );

  modport slave (
    input  play, tick, spawn, btn,
    output hit, miss, score, streak, overflow, dbg_state
  );
endinterface

// File: rtl/note_hit_scorer.sv
// Three-lane rhythm-game note tracker and hit judge.
// Each lane holds SLOTS notes that travel from position 0 towards HIT_HI.
// The rising edge of a button judges the note that is furthest along inside
// the hit window. A note that travels past HIT_HI escapes and counts as a miss.
module note_hit_scorer #(
  parameter int SLOTS  = 4,
  parameter int HIT_LO = 440,
  parameter int HIT_HI = 490
) (
  input  logic               clk,
  input  logic               reset,
  note_hit_scorer_if.slave   bus
);

  localparam int          IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [9:0]  LO    = 10'(HIT_LO);
  localparam logic [9:0]  HI    = 10'(HIT_HI);

  // The game state is a direct decode of play, so it has no register of its
  // own. It is still exported for observation.
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           w_state;

  // Board state
  logic [SLOTS-1:0] r_valid [3];
  logic [9:0]       r_pos   [3][SLOTS];
  logic [2:0]       r_btn_q;
  logic [2:0]       r_hit;
  logic [2:0]       r_miss;
  logic [7:0]       r_score;
  logic [5:0]       r_streak;
  logic             r_overflow;

  // Judging and next-state wires
  logic [2:0]       w_press;
  logic [2:0]       w_found;
  logic [IDX_W-1:0] w_hit_idx  [3];
  logic [9:0]       w_best_pos [3];
  logic [SLOTS-1:0] w_valid_nxt [3];
  logic [9:0]       w_pos_nxt   [3][SLOTS];
  logic [2:0]       w_hit;
  logic [2:0]       w_miss;
  logic [2:0]       w_escape;
  logic [2:0]       w_placed;
  logic             w_drop;
  logic [1:0]       w_n_hits;
  logic [8:0]       w_score_sum;
  logic [6:0]       w_streak_sum;
  logic [7:0]       w_score_nxt;
  logic [5:0]       w_streak_nxt;

  // Decode the game state from play.
  always_comb begin
    w_state = bus.play ? ST_RUN : ST_IDLE;
  end

  // Detect button edges, then pick each lane's hit candidate. The candidate is
  // the valid slot inside the window with the largest position. The strict '>'
  // makes the lower index win a tie.
  always_comb begin
    w_press = bus.btn & ~r_btn_q;
    for (int l = 0; l < 3; l++) begin
      w_found[l]    = 1'b0;
      w_hit_idx[l]  = '0;
      w_best_pos[l] = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (r_valid[l][s] && (r_pos[l][s] >= LO) && (r_pos[l][s] <= HI) &&
            (!w_found[l] || (r_pos[l][s] > w_best_pos[l]))) begin
          w_found[l]    = 1'b1;
          w_hit_idx[l]  = IDX_W'(s);
          w_best_pos[l] = r_pos[l][s];
        end
      end
    end
  end

  // Update slots from the pre-update positions. A hit slot is cleared rather
  // than advanced. Escapes are cleared on a tick. A spawn only claims a slot
  // that was already free before this edge.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      w_valid_nxt[l] = r_valid[l];
      for (int s = 0; s < SLOTS; s++) begin
        w_pos_nxt[l][s] = r_pos[l][s];
      end
    end
    w_hit    = '0;
    w_miss   = '0;
    w_escape = '0;
    w_placed = '0;
    w_drop   = 1'b0;

    if (w_state == ST_RUN) begin
      for (int l = 0; l < 3; l++) begin
        w_hit[l] = w_press[l] & w_found[l];

        for (int s = 0; s < SLOTS; s++) begin
          if (r_valid[l][s]) begin
            if (w_hit[l] && (w_hit_idx[l] == IDX_W'(s))) begin
              w_valid_nxt[l][s] = 1'b0;
              w_pos_nxt[l][s]   = '0;
            end else if (bus.tick) begin
              if (r_pos[l][s] == HI) begin
                w_valid_nxt[l][s] = 1'b0;
                w_pos_nxt[l][s]   = '0;
                w_escape[l]       = 1'b1;
              end else begin
                w_pos_nxt[l][s] = r_pos[l][s] + 10'd1;
              end
            end
          end
        end

        // One judgement per lane per cycle. A hit masks a same-cycle escape.
        w_miss[l] = (w_press[l] & ~w_found[l]) | (w_escape[l] & ~w_hit[l]);

        if (bus.spawn[l]) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (!r_valid[l][s] && !w_placed[l]) begin
              w_valid_nxt[l][s] = 1'b1;
              w_pos_nxt[l][s]   = '0;
              w_placed[l]       = 1'b1;
            end
          end
          if (!w_placed[l]) begin
            w_drop = 1'b1;
          end
        end
      end
    end
  end

  // Apply saturating score and streak arithmetic. Any miss resets the streak.
  always_comb begin
    w_n_hits     = {1'b0, w_hit[0]} + {1'b0, w_hit[1]} + {1'b0, w_hit[2]};
    w_score_sum  = {1'b0, r_score} + {7'd0, w_n_hits};
    w_streak_sum = {1'b0, r_streak} + {5'd0, w_n_hits};
    w_score_nxt  = (w_score_sum > 9'd255) ? 8'd255 : w_score_sum[7:0];
    if (|w_miss) begin
      w_streak_nxt = '0;
    end else begin
      w_streak_nxt = (w_streak_sum > 7'd63) ? 6'd63 : w_streak_sum[5:0];
    end
  end

  // Hold all game state. Reset clears it asynchronously. overflow is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 3; l++) begin
        r_valid[l] <= '0;
        for (int s = 0; s < SLOTS; s++) begin
          r_pos[l][s] <= '0;
        end
      end
      r_btn_q    <= '0;
      r_hit      <= '0;
      r_miss     <= '0;
      r_score    <= '0;
      r_streak   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int l = 0; l < 3; l++) begin
        r_valid[l] <= w_valid_nxt[l];
        for (int s = 0; s < SLOTS; s++) begin
          r_pos[l][s] <= w_pos_nxt[l][s];
        end
      end
      r_btn_q  <= bus.btn;
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_score  <= w_score_nxt;
      r_streak <= w_streak_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.hit       = r_hit;
  assign bus.miss      = r_miss;
  assign bus.score     = r_score;
  assign bus.streak    = r_streak;
  assign bus.overflow  = r_overflow;
  assign bus.dbg_state = (w_state == ST_RUN);

endmodule
